// File: rtl/ram8_pkg.sv
// Shared constants and helpers for the eight-word RAM.
package ram8_pkg;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_FULL = 4'd8;

    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction
endpackage

// File: rtl/ram8_if.sv
// Data/address/status bundle between a RAM user (master) and ram8 (slave).
interface ram8_if #(parameter int WIDTH = ram8_pkg::WIDTH);
    import ram8_pkg::*;

    logic [WIDTH-1:0]  in;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  out;
    logic [CNT_W-1:0]  busy_cnt;
    logic              full;

    modport master (output in, load, address, input out, busy_cnt, full);
    modport slave  (input in, load, address, output out, busy_cnt, full);
endinterface

// File: rtl/ram8_register16.sv
// One storage word: loadable register with synchronous clear.
module register16 #(
    parameter int WIDTH = ram8_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Word update: clear has priority over load
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= {WIDTH{1'b0}};
        end else if (load) begin
            out <= in;
        end else begin
            out <= out;
        end
    end

endmodule

// File: rtl/ram8.sv
// Eight-word RAM with combinational read and a saturating count of words written.
module ram8 #(
    parameter int WIDTH = ram8_pkg::WIDTH,
    parameter int DEPTH = ram8_pkg::DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    ram8_if.slave bus
);
    import ram8_pkg::*;

    logic [DEPTH-1:0] we_s;
    logic [WIDTH-1:0] word_s [DEPTH];
    logic [DEPTH-1:0] written_r;
    logic [CNT_W-1:0] busy_cnt_r;
    logic             full_r;

    // One-hot write enable decode
    always_comb begin
        we_s = {DEPTH{1'b0}};
        if (bus.load) begin
            we_s[bus.address] = 1'b1;
        end else begin
            we_s = {DEPTH{1'b0}};
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        register16 #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .reset (reset),
            .load  (we_s[g]),
            .in    (bus.in),
            .out   (word_s[g])
        );
    end

    // Read mux: zero latency, no bypass of write data
    always_comb begin
        bus.out = word_s[bus.address];
    end

    // Written flags and status; the count samples the flags, so it lags a write by one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            written_r  <= {DEPTH{1'b0}};
            busy_cnt_r <= {CNT_W{1'b0}};
            full_r     <= 1'b0;
        end else begin
            written_r  <= written_r | we_s;
            busy_cnt_r <= popcount(written_r);
            full_r     <= (popcount(written_r) == CNT_FULL);
        end
    end

    assign bus.busy_cnt = busy_cnt_r;
    assign bus.full     = full_r;

endmodule

// File: doc/ram8.md
RAM8 -- requirements
Module: ram8

Interface
REQ-001 Parameter: WIDTH, 16, data word width in bits.
REQ-002 Parameter: DEPTH, 8, number of words; fixed at 8, so the address is 3 bits.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled only on the rising edge of clk.
REQ-005 Port: in  input  WIDTH  write data; typically driven by the 16-bit gate outputs (Or16 and siblings).
REQ-006 Port: load  input  1  write enable for the word selected by address.
REQ-007 Port: address  input  3  selects the word for both write and read.
REQ-008 Port: out  output  WIDTH  read data for the word selected by address.
REQ-009 Port: busy_cnt  output  4  count of words written since reset, saturating at 8.
REQ-010 Port: full  output  1  high when all 8 words have been written at least once since reset.

Function
REQ-011 Write: on a rising clk edge with load=1 and reset=0, word[address] shall take in; all other words shall hold.
REQ-012 Hold: with load=0, no word shall change.
REQ-013 Read: out shall be combinational, equal to word[address] as currently stored; read latency from an address change shall be 0 cycles.
REQ-014 Write visibility: a value written at edge N shall appear on out from just after edge N when address is unchanged; there is no same-cycle bypass of in to out.
REQ-015 Written-flag vector: each word shall have a 1-bit written flag, set on its first write after reset.
REQ-016 busy_cnt: shall equal the population count of the written flags, registered, and shall update in the cycle after the write edge.
REQ-017 Rewriting an already-written word shall update its data and shall leave busy_cnt unchanged.
REQ-018 full shall be 1 exactly when busy_cnt == 8; it shall stay 1 until reset.
REQ-019 Address decode: exactly one word shall be enabled when load=1; no word shall be enabled when load=0.
REQ-020 Data path: no arithmetic is performed; widths shall match exactly, with no truncation or extension.

Reset
REQ-021 On a rising clk edge with reset=1: all words shall clear to 0, all written flags shall clear, busy_cnt shall be 0 and full shall be 0.
REQ-022 Reset has priority: load=1 in the same cycle as reset=1 shall be ignored.
REQ-023 After reset, out shall read 0 for every address.
REQ-024 Before the first reset edge, contents are undefined; the bench shall not check them.
REQ-025 Reset asserted in the middle of a write sequence shall discard all prior writes; counting restarts at 0.

Structure
REQ-026 A shared package shall hold WIDTH, DEPTH and the address width constant (3).
REQ-027 Sub-module register16: WIDTH-bit register with in, load, clk and reset ports, and out; ram8 instantiates it 8 times, one per word.
REQ-028 The address decode and the output mux shall live inside ram8, with no separate module.
REQ-029 busy_cnt and full logic shall live inside ram8.

Verification
REQ-030 Reset, then read addresses 0..7 -> out=0x0000 for each; busy_cnt=0; full=0.
REQ-031 Write 0xA5A5 to addr 3, then read addr 3 and addr 4 -> 0xA5A5 and 0x0000; busy_cnt=1 one cycle after the write.
REQ-032 Write 0x1234 to addr 3 again, then read addr 3 -> 0x1234; busy_cnt stays 1.
REQ-033 Write 0xFFFF, 0x0001, 0x8000, 0x00FF, 0x7FFE, 0xF0F0, 0x0F0F, 0x5555 to addr 0..7 -> each reads back exactly; busy_cnt=8 and full=1 after the last write.
REQ-034 Assert load=1, address=2, in=0xBEEF together with reset=1 -> addr 2 reads 0x0000; busy_cnt=0.
REQ-035 Hold load=0 and sweep in through random values over 20 cycles -> all 8 stored words are unchanged.
